// File: rtl/lfsr_stream_cipher.sv
// LFSR keystream encrypter/decrypter with runtime reseed, warm-up phase,
// lock-up guard, per-word bypass and a single registered output stage.
//
// Handshake: a word moves across an interface on a rising clk edge where
// valid and ready are both high. in_ready may depend combinationally on
// out_ready and seed_valid. out_valid/out_data come straight from flops and
// hold steady while out_valid && !out_ready.
module lfsr_stream_cipher #(
  parameter int                 WIDTH  = 8,
  parameter int                 DATA_W = 8,
  parameter logic [WIDTH-1:0]   TAPS   = 8'hE1,
  parameter logic [WIDTH-1:0]   SEED   = 8'h41,
  parameter int unsigned        WARMUP = 0,
  parameter int                 CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_valid,
  input  logic [WIDTH-1:0]  seed_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  words_done
);

  // Warm-up counter covers WARMUP in 0..255.
  localparam logic [7:0] WARM_INIT = 8'(WARMUP);

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e ST_INIT = (WARMUP == 0) ? ST_RUN : ST_WARM;

  state_e             state_q, state_d;
  logic [7:0]         warm_q, warm_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic [WIDTH-1:0]   lfsr_step;

  // Fibonacci step; an all-zero result would freeze the register, so the
  // seed is substituted instead.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] n;
    n = {s[WIDTH-2:0], ^(s & TAPS)};
    if (n == '0) n = SEED;
    return n;
  endfunction

  assign lfsr_step = lfsr_next(lfsr_q);
  assign accept    = in_valid && in_ready;

  // FSM state register: warm-up counter and mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      warm_q  <= WARM_INIT;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  // FSM next state: reseed restarts warm-up, WARM counts down to RUN.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    if (seed_valid) begin
      state_d = ST_INIT;
      warm_d  = WARM_INIT;
    end else if (state_q == ST_WARM) begin
      warm_d = warm_q - 8'd1;
      if (warm_q <= 8'd1) state_d = ST_RUN;
    end
  end

  // FSM outputs: input accepted only in RUN, never during a reseed cycle.
  always_comb begin
    busy     = (state_q == ST_WARM);
    in_ready = rst_n && (state_q == ST_RUN) && !seed_valid &&
               (!out_valid_q || out_ready);
  end

  // Datapath registers: LFSR, output stage and word counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q      <= SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

  // Datapath next state: reseed, warm-up stepping, or accepting a word.
  always_comb begin
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    // A delivered word frees the stage unless refilled below.
    if (out_ready) out_valid_d = 1'b0;
    if (seed_valid) begin
      lfsr_d = (seed_data == '0) ? SEED : seed_data;
      cnt_d  = '0;
    end else if (state_q == ST_WARM) begin
      lfsr_d = lfsr_step;
    end else if (accept) begin
      out_valid_d = 1'b1;
      if (in_bypass) begin
        out_data_d = in_data;
      end else begin
        out_data_d = in_data ^ lfsr_q[DATA_W-1:0];
        lfsr_d     = lfsr_step;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign words_done = cnt_q;

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Bench for lfsr_stream_cipher: a WARMUP=0 instance (a_*) and a WARMUP=2
// instance (b_*), directed scenarios plus a randomized scoreboard run.
module tb_lfsr_stream_cipher;

  localparam logic [7:0] TAPS_TB = 8'hE1;
  localparam logic [7:0] SEED_TB = 8'h41;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a_seed_valid = 0, a_in_valid = 0, a_in_bypass = 0, a_out_ready = 1;
  logic [7:0] a_seed_data = 0, a_in_data = 0;
  logic       a_in_ready, a_out_valid, a_busy;
  logic [7:0] a_out_data;
  logic [15:0] a_words_done;

  logic       b_seed_valid = 0, b_in_valid = 0, b_in_bypass = 0, b_out_ready = 1;
  logic [7:0] b_seed_data = 0, b_in_data = 0;
  logic       b_in_ready, b_out_valid, b_busy;
  logic [7:0] b_out_data;
  logic [15:0] b_words_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  lfsr_stream_cipher #(.WARMUP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed_valid(a_seed_valid), .seed_data(a_seed_data),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_bypass(a_in_bypass), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .busy(a_busy), .words_done(a_words_done)
  );

  lfsr_stream_cipher #(.WARMUP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .seed_valid(b_seed_valid), .seed_data(b_seed_data),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_bypass(b_in_bypass), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .busy(b_busy), .words_done(b_words_done)
  );

  // Reference keystream step: shift left, new bit = parity of tapped bits.
  function automatic logic [7:0] m_step(input logic [7:0] s);
    logic [7:0] n;
    n = 8'((s << 1) | ($countones(s & TAPS_TB) % 2));
    if (n == 8'h00) n = SEED_TB;
    return n;
  endfunction

  // driver tasks; all stimulus changes happen just after a falling edge
  task automatic step_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_seed_valid = 0; a_seed_data = 0; a_in_valid = 0; a_in_data = 0;
    a_in_bypass = 0; a_out_ready = 1;
    b_seed_valid = 0; b_seed_data = 0; b_in_valid = 0; b_in_data = 0;
    b_in_bypass = 0; b_out_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step_clk();
    step_clk();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", a_out_valid); end
    n_checks++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h exp 00", a_out_data); end
    n_checks++; if (a_words_done !== 16'd0) begin n_fail++; $display("FAIL reset_words_done: got %0d exp 0", a_words_done); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_w0: got %b exp 0", a_busy); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_w0: got %b exp 1", a_in_ready); end
    n_checks++; if (b_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_w2: got %b exp 1", b_busy); end
    n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_w2: got %b exp 0", b_in_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_w [3];
    exp_w[0] = 8'h41; exp_w[1] = 8'h82; exp_w[2] = 8'h05;
    do_reset();
    a_in_valid = 1; a_in_data = 8'h00; a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d]: got %b exp 1", i, a_out_valid); end
      n_checks++; if (a_out_data !== exp_w[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h exp %h", i, a_out_data, exp_w[i]); end
    end
    a_in_valid = 0;
    step_clk();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b exp 0", a_out_valid); end
    n_checks++; if (a_words_done !== 16'd3) begin n_fail++; $display("FAIL basic_words_done: got %0d exp 3", a_words_done); end
  endtask

  task automatic test_backpressure();
    do_reset();
    a_in_valid = 1; a_in_data = 8'hFF; a_out_ready = 1;
    step_clk();
    n_checks++; if (a_out_data !== 8'hBE) begin n_fail++; $display("FAIL bp_first: got %h exp be", a_out_data); end
    a_in_data = 8'h00; a_out_ready = 0;
    #1;
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b exp 0", a_in_ready); end
    for (int i = 0; i < 2; i++) begin
      step_clk();
      n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hBE) begin n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h exp 1/be", i, a_out_valid, a_out_data); end
    end
    a_out_ready = 1;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 1", a_in_ready); end
    step_clk();
    n_checks++; if (a_out_data !== 8'h82) begin n_fail++; $display("FAIL bp_next: got %h exp 82", a_out_data); end
    a_in_valid = 0;
    step_clk();
    n_checks++; if (a_words_done !== 16'd2) begin n_fail++; $display("FAIL bp_words_done: got %0d exp 2", a_words_done); end
  endtask

  task automatic test_bypass();
    do_reset();
    a_in_valid = 1; a_in_data = 8'h5A; a_in_bypass = 1;
    step_clk();
    n_checks++; if (a_out_data !== 8'h5A) begin n_fail++; $display("FAIL byp_word: got %h exp 5a", a_out_data); end
    a_in_data = 8'h00; a_in_bypass = 0;
    step_clk();
    n_checks++; if (a_out_data !== 8'h41) begin n_fail++; $display("FAIL byp_after: got %h exp 41", a_out_data); end
    a_in_valid = 0;
    step_clk();
    n_checks++; if (a_words_done !== 16'd1) begin n_fail++; $display("FAIL byp_words_done: got %0d exp 1", a_words_done); end
  endtask

  task automatic test_reseed_zero();
    do_reset();
    a_in_valid = 1; a_in_data = 8'h00;
    step_clk();
    n_checks++; if (a_words_done !== 16'd1) begin n_fail++; $display("FAIL rs_pre_count: got %0d exp 1", a_words_done); end
    a_seed_valid = 1; a_seed_data = 8'h00; a_in_data = 8'h33; a_out_ready = 0;
    #1;
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rs_in_ready: got %b exp 0", a_in_ready); end
    step_clk();
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h41) begin n_fail++; $display("FAIL rs_pending: got %b/%h exp 1/41", a_out_valid, a_out_data); end
    n_checks++; if (a_words_done !== 16'd0) begin n_fail++; $display("FAIL rs_count_clear: got %0d exp 0", a_words_done); end
    a_seed_valid = 0; a_in_data = 8'h00; a_out_ready = 1;
    step_clk();
    n_checks++; if (a_out_data !== 8'h41) begin n_fail++; $display("FAIL rs_first: got %h exp 41", a_out_data); end
    n_checks++; if (a_words_done !== 16'd1) begin n_fail++; $display("FAIL rs_count: got %0d exp 1", a_words_done); end
    a_in_valid = 0;
    step_clk();
  endtask

  task automatic test_warmup();
    logic [7:0] ks;
    do_reset();
    b_in_valid = 1; b_in_data = 8'h00;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (b_busy !== 1'b1 || b_in_ready !== 1'b0) begin n_fail++; $display("FAIL wu_busy[%0d]: got %b/%b exp 1/0", i, b_busy, b_in_ready); end
      step_clk();
    end
    #1;
    n_checks++; if (b_busy !== 1'b0 || b_in_ready !== 1'b1) begin n_fail++; $display("FAIL wu_run: got %b/%b exp 0/1", b_busy, b_in_ready); end
    step_clk();
    ks = m_step(m_step(SEED_TB));
    n_checks++; if (b_out_data !== ks) begin n_fail++; $display("FAIL wu_first: got %h exp %h", b_out_data, ks); end
    b_in_valid = 0; b_seed_valid = 1; b_seed_data = 8'h82;
    step_clk();
    b_seed_valid = 0; b_in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (b_busy !== 1'b1 || b_in_ready !== 1'b0) begin n_fail++; $display("FAIL wu_rs_busy[%0d]: got %b/%b exp 1/0", i, b_busy, b_in_ready); end
      step_clk();
    end
    step_clk();
    ks = m_step(m_step(8'h82));
    n_checks++; if (b_out_data !== ks) begin n_fail++; $display("FAIL wu_rs_first: got %h exp %h", b_out_data, ks); end
    n_checks++; if (b_words_done !== 16'd1) begin n_fail++; $display("FAIL wu_rs_count: got %0d exp 1", b_words_done); end
    b_in_valid = 0;
    step_clk();
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_in_valid = 1; a_in_data = 8'h12;
    step_clk();
    a_in_valid = 0; a_out_ready = 0; rst_n = 0;
    #1;
    n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_no_async: got %b exp 1", a_out_valid); end
    step_clk();
    n_checks++; if (a_out_valid !== 1'b0 || a_out_data !== 8'h00) begin n_fail++; $display("FAIL rm_out: got %b/%h exp 0/00", a_out_valid, a_out_data); end
    n_checks++; if (a_words_done !== 16'd0) begin n_fail++; $display("FAIL rm_count: got %0d exp 0", a_words_done); end
    rst_n = 1; a_out_ready = 1; a_in_valid = 1; a_in_data = 8'h00;
    step_clk();
    n_checks++; if (a_out_data !== SEED_TB) begin n_fail++; $display("FAIL rm_seed: got %h exp %h", a_out_data, SEED_TB); end
    a_in_valid = 0;
    step_clk();
  endtask

  // Random traffic on the WARMUP=0 instance against a keystream model and
  // an expected-word queue.
  task automatic test_random();
    logic [7:0]  m_ks;
    logic [15:0] m_cnt;
    logic [7:0]  w;
    logic        exp_rdy;
    do_reset();
    exp_q.delete();
    m_ks = SEED_TB; m_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      a_in_valid   = ($urandom_range(0, 3) != 0);
      a_in_data    = 8'($urandom_range(0, 255));
      a_in_bypass  = ($urandom_range(0, 4) == 0);
      a_out_ready  = ($urandom_range(0, 3) != 0);
      a_seed_valid = ($urandom_range(0, 19) == 0);
      a_seed_data  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      #1;
      exp_rdy = !a_seed_valid && (exp_q.size() == 0 || a_out_ready);
      n_checks++; if (a_in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b exp %b", cyc, a_in_ready, exp_rdy); end
      n_checks++; if (a_out_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_out_valid[%0d]: got %b exp %b", cyc, a_out_valid, exp_q.size() != 0); end
      if (a_out_valid && a_out_ready && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        n_checks++; if (a_out_data !== w) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h exp %h", cyc, a_out_data, w); end
      end
      if (a_seed_valid) begin
        m_ks  = (a_seed_data == 8'h00) ? SEED_TB : a_seed_data;
        m_cnt = 0;
      end else if (a_in_valid && exp_rdy) begin
        if (a_in_bypass) begin
          exp_q.push_back(a_in_data);
        end else begin
          exp_q.push_back(a_in_data ^ m_ks);
          m_ks = m_step(m_ks);
          if (m_cnt != 16'hFFFF) m_cnt++;
        end
      end
      step_clk();
      n_checks++; if (a_words_done !== m_cnt) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d exp %0d", cyc, a_words_done, m_cnt); end
    end
    idle_inputs();
    step_clk();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_bypass();
    test_reseed_zero();
    test_warmup();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
